// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM: fetch/decode/execute/mem/writeback sequencing
// with memory handshake, wait timeout, illegal-op trap and retired counter.
module multicycle_controller #(
  parameter int WIDTH_OP  = 7,
  parameter int WIDTH_2   = 2,
  parameter int WIDTH_3   = 3,
  parameter int TIMEOUT   = 16,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH_OP-1:0]  op,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 adr_src,
  output logic                 mem_write,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 branch,
  output logic                 reg_write,
  output logic [WIDTH_2-1:0]   result_src,
  output logic [WIDTH_2-1:0]   alu_src_a,
  output logic [WIDTH_2-1:0]   alu_src_b,
  output logic [WIDTH_3-1:0]   imm_src,
  output logic [WIDTH_3-1:0]   alu_op,
  output logic                 illegal,
  output logic                 bus_err,
  output logic [CNT_WIDTH-1:0] retired
);

  localparam int TW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int LIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  localparam logic [WIDTH_OP-1:0] OP_R     = WIDTH_OP'(7'b0110011);
  localparam logic [WIDTH_OP-1:0] OP_LOAD  = WIDTH_OP'(7'b0000011);
  localparam logic [WIDTH_OP-1:0] OP_IALU  = WIDTH_OP'(7'b0010011);
  localparam logic [WIDTH_OP-1:0] OP_S     = WIDTH_OP'(7'b0100011);
  localparam logic [WIDTH_OP-1:0] OP_B     = WIDTH_OP'(7'b1100011);
  localparam logic [WIDTH_OP-1:0] OP_AUIPC = WIDTH_OP'(7'b0010111);
  localparam logic [WIDTH_OP-1:0] OP_LUI   = WIDTH_OP'(7'b0110111);
  localparam logic [WIDTH_OP-1:0] OP_JALR  = WIDTH_OP'(7'b1100111);
  localparam logic [WIDTH_OP-1:0] OP_JAL   = WIDTH_OP'(7'b1101111);

  typedef enum logic [4:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB,
    S_MEMWRITE, S_EXEC_R, S_EXEC_I, S_ALUWB, S_BRANCH,
    S_JAL, S_JALR, S_JALR_PC, S_LUI, S_AUIPC,
    S_ILLEGAL, S_BUS_ERR
  } state_t;

  state_t          state;
  state_t          nxt;
  logic [TW-1:0]   wait_cnt;
  logic            req_st;
  logic            waiting;
  logic            time_up;
  logic            retire;
  logic [WIDTH_3-1:0] imm_dec;

  assign req_st  = (state == S_FETCH) || (state == S_MEMREAD) ||
                   (state == S_MEMWRITE);
  assign waiting = req_st && !mem_ready;
  assign time_up = (TIMEOUT > 0) && waiting && (wait_cnt == TW'(LIM));
  assign retire  = (nxt == S_FETCH) &&
                   ((state == S_MEMWB) || (state == S_MEMWRITE) ||
                    (state == S_ALUWB) || (state == S_BRANCH));

  always_comb begin
    imm_dec = '0;
    unique case (op)
      OP_LOAD, OP_IALU, OP_JALR: imm_dec = WIDTH_3'(3'b001);
      OP_LUI, OP_AUIPC:          imm_dec = WIDTH_3'(3'b010);
      OP_S:                      imm_dec = WIDTH_3'(3'b011);
      OP_B:                      imm_dec = WIDTH_3'(3'b100);
      OP_JAL:                    imm_dec = WIDTH_3'(3'b101);
      default:                   imm_dec = '0;
    endcase
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_FETCH: begin
        if (mem_ready)    nxt = S_DECODE;
        else if (time_up) nxt = S_BUS_ERR;
      end
      S_DECODE: begin
        unique case (op)
          OP_LOAD, OP_S: nxt = S_MEMADR;
          OP_R:          nxt = S_EXEC_R;
          OP_IALU:       nxt = S_EXEC_I;
          OP_B:          nxt = S_BRANCH;
          OP_JAL:        nxt = S_JAL;
          OP_JALR:       nxt = S_JALR;
          OP_LUI:        nxt = S_LUI;
          OP_AUIPC:      nxt = S_AUIPC;
          default:       nxt = S_ILLEGAL;
        endcase
      end
      S_MEMADR:   nxt = (op == OP_S) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD: begin
        if (mem_ready)    nxt = S_MEMWB;
        else if (time_up) nxt = S_BUS_ERR;
      end
      S_MEMWRITE: begin
        if (mem_ready)    nxt = S_FETCH;
        else if (time_up) nxt = S_BUS_ERR;
      end
      S_MEMWB, S_ALUWB, S_BRANCH:    nxt = S_FETCH;
      S_EXEC_R, S_EXEC_I:            nxt = S_ALUWB;
      S_JAL, S_JALR_PC:              nxt = S_ALUWB;
      S_LUI, S_AUIPC:                nxt = S_ALUWB;
      S_JALR:                        nxt = S_JALR_PC;
      S_ILLEGAL, S_BUS_ERR:          nxt = state;
      default:                       nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
      retired  <= '0;
    end else begin
      state <= nxt;
      if (nxt != state)  wait_cnt <= '0;
      else if (waiting)  wait_cnt <= wait_cnt + 1'b1;
      if (retire)        retired  <= retired + 1'b1;
    end
  end

  // Reset forces every control low even though the state sits in FETCH.
  always_comb begin
    mem_req    = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    branch     = 1'b0;
    reg_write  = 1'b0;
    result_src = '0;
    alu_src_a  = '0;
    alu_src_b  = '0;
    imm_src    = '0;
    alu_op     = '0;
    illegal    = 1'b0;
    bus_err    = 1'b0;
    if (rst_n) begin
      if ((state != S_FETCH) && (state != S_ILLEGAL) &&
          (state != S_BUS_ERR))
        imm_src = imm_dec;
      unique case (state)
        S_FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_write   = 1'b1;
            pc_write   = 1'b1;
            alu_src_b  = WIDTH_2'(2'b10);
            alu_op     = WIDTH_3'(3'b001);
            result_src = WIDTH_2'(2'b10);
          end
        end
        S_DECODE: begin
          alu_src_a = WIDTH_2'(2'b01);
          alu_src_b = WIDTH_2'(2'b01);
          alu_op    = WIDTH_3'(3'b001);
        end
        S_MEMADR: begin
          alu_src_a = WIDTH_2'(2'b10);
          alu_src_b = WIDTH_2'(2'b01);
          alu_op    = (op == OP_S) ? WIDTH_3'(3'b010) : WIDTH_3'(3'b001);
        end
        S_MEMREAD: begin
          mem_req = 1'b1;
          adr_src = 1'b1;
        end
        S_MEMWB: begin
          result_src = WIDTH_2'(2'b01);
          reg_write  = 1'b1;
        end
        S_MEMWRITE: begin
          mem_req   = 1'b1;
          adr_src   = 1'b1;
          mem_write = 1'b1;
        end
        S_EXEC_R: begin
          alu_src_a = WIDTH_2'(2'b10);
        end
        S_EXEC_I: begin
          alu_src_a = WIDTH_2'(2'b10);
          alu_src_b = WIDTH_2'(2'b01);
        end
        S_ALUWB: reg_write = 1'b1;
        S_BRANCH: begin
          alu_src_a = WIDTH_2'(2'b10);
          alu_op    = WIDTH_3'(3'b011);
          branch    = 1'b1;
        end
        S_JAL, S_JALR_PC: begin
          pc_write  = 1'b1;
          alu_src_a = WIDTH_2'(2'b01);
          alu_src_b = WIDTH_2'(2'b10);
          alu_op    = WIDTH_3'(3'b001);
        end
        S_JALR: begin
          alu_src_a = WIDTH_2'(2'b10);
          alu_src_b = WIDTH_2'(2'b01);
          alu_op    = WIDTH_3'(3'b110);
        end
        S_LUI: begin
          alu_src_b = WIDTH_2'(2'b01);
          alu_op    = WIDTH_3'(3'b101);
        end
        S_AUIPC: begin
          alu_src_a = WIDTH_2'(2'b01);
          alu_src_b = WIDTH_2'(2'b01);
          alu_op    = WIDTH_3'(3'b100);
        end
        S_ILLEGAL: illegal = 1'b1;
        S_BUS_ERR: bus_err = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle control vectors,
// retired count, illegal trap, memory timeout and async reset.
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  op;
  logic        mem_ready;
  logic        mem_req, adr_src, mem_write, ir_write, pc_write;
  logic        branch, reg_write, illegal, bus_err;
  logic [1:0]  result_src, alu_src_a, alu_src_b;
  logic [2:0]  imm_src, alu_op;
  logic [31:0] retired;

  int checks = 0;
  int errors = 0;

  multicycle_controller #(
    .WIDTH_OP(7), .WIDTH_2(2), .WIDTH_3(3),
    .TIMEOUT(4), .CNT_WIDTH(32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
    .mem_req(mem_req), .adr_src(adr_src), .mem_write(mem_write),
    .ir_write(ir_write), .pc_write(pc_write), .branch(branch),
    .reg_write(reg_write), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .imm_src(imm_src), .alu_op(alu_op), .illegal(illegal),
    .bus_err(bus_err), .retired(retired)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] R = 7'b0110011, LD = 7'b0000011;
  localparam logic [6:0] IA = 7'b0010011, ST = 7'b0100011;
  localparam logic [6:0] BR = 7'b1100011, AU = 7'b0010111;
  localparam logic [6:0] LU = 7'b0110111, JR = 7'b1100111;
  localparam logic [6:0] JL = 7'b1101111;

  // {mreq,adr,mw,irw,pcw,br,rw,rs,a,b,imm,aop,ill,be}
  function automatic logic [20:0] v(
    input logic mr, ad, mw, ir, pc, br, rw,
    input logic [1:0] rs, a, b,
    input logic [2:0] im, ao,
    input logic il, be);
    return {mr, ad, mw, ir, pc, br, rw, rs, a, b, im, ao, il, be};
  endfunction

  function automatic logic [20:0] obs();
    return {mem_req, adr_src, mem_write, ir_write, pc_write, branch,
            reg_write, result_src, alu_src_a, alu_src_b, imm_src,
            alu_op, illegal, bus_err};
  endfunction

  task automatic chk(input string tag, input logic [20:0] e);
    logic [20:0] o;
    o = obs();
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, o, e);
    end
  endtask

  task automatic chk_ret(input string tag, input logic [31:0] e);
    checks++;
    assert (retired === e) else begin
      errors++;
      $error("FAIL %s retired got %0d exp %0d", tag, retired, e);
    end
  endtask

  task automatic step(input string tag, input logic rdy,
                      input logic [20:0] e);
    mem_ready = rdy;
    #1;
    chk(tag, e);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("reset_out", '0);
    chk_ret("reset_ret", 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [20:0] f_w, f_r, z;

  function automatic logic [20:0] dec(input logic [2:0] im);
    return v(0,0,0,0,0,0,0, 2'b00,2'b01,2'b01, im,3'b001, 0,0);
  endfunction
  function automatic logic [20:0] wb(input logic [2:0] im);
    return v(0,0,0,0,0,0,1, 2'b00,2'b00,2'b00, im,3'b000, 0,0);
  endfunction

  initial begin
    rst_n = 1'b0;
    op = R;
    mem_ready = 1'b0;
    f_w = v(1,0,0,0,0,0,0, 2'b00,2'b00,2'b00, 3'b000,3'b000, 0,0);
    f_r = v(1,0,0,1,1,0,0, 2'b10,2'b00,2'b10, 3'b000,3'b001, 0,0);
    z   = '0;
    @(negedge clk);
    do_reset();

    op = R;
    step("r_fetch", 1, f_r);
    step("r_dec", 0, dec(3'b000));
    step("r_exec", 1, v(0,0,0,0,0,0,0, 2'b00,2'b10,2'b00, 3'b000,3'b000, 0,0));
    step("r_wb", 0, wb(3'b000));
    chk_ret("r_ret", 32'd1);

    op = LD;
    step("ld_fetch", 1, f_r);
    step("ld_dec", 1, dec(3'b001));
    step("ld_adr", 1, v(0,0,0,0,0,0,0, 2'b00,2'b10,2'b01, 3'b001,3'b001, 0,0));
    for (int i = 0; i < 3; i++)
      step("ld_wait", 0, v(1,1,0,0,0,0,0, 2'b00,2'b00,2'b00, 3'b001,3'b000, 0,0));
    step("ld_read", 1, v(1,1,0,0,0,0,0, 2'b00,2'b00,2'b00, 3'b001,3'b000, 0,0));
    step("ld_wb", 0, v(0,0,0,0,0,0,1, 2'b01,2'b00,2'b00, 3'b001,3'b000, 0,0));
    chk_ret("ld_ret", 32'd2);

    op = ST;
    step("st_fetch", 1, f_r);
    step("st_dec", 0, dec(3'b011));
    step("st_adr", 0, v(0,0,0,0,0,0,0, 2'b00,2'b10,2'b01, 3'b011,3'b010, 0,0));
    step("st_wr", 1, v(1,1,1,0,0,0,0, 2'b00,2'b00,2'b00, 3'b011,3'b000, 0,0));
    chk_ret("st_ret", 32'd3);

    op = JL;
    step("jal_fetch", 1, f_r);
    step("jal_dec", 0, dec(3'b101));
    step("jal_pc", 1, v(0,0,0,0,1,0,0, 2'b00,2'b01,2'b10, 3'b101,3'b001, 0,0));
    step("jal_wb", 1, wb(3'b101));
    chk_ret("jal_ret", 32'd4);

    op = JR;
    step("jalr_fetch", 1, f_r);
    step("jalr_dec", 0, dec(3'b001));
    step("jalr_alu", 1, v(0,0,0,0,0,0,0, 2'b00,2'b10,2'b01, 3'b001,3'b110, 0,0));
    step("jalr_pc", 0, v(0,0,0,0,1,0,0, 2'b00,2'b01,2'b10, 3'b001,3'b001, 0,0));
    step("jalr_wb", 0, wb(3'b001));
    chk_ret("jalr_ret", 32'd5);

    op = BR;
    step("b_fetch", 1, f_r);
    step("b_dec", 0, dec(3'b100));
    step("b_cmp", 1, v(0,0,0,0,0,1,0, 2'b00,2'b10,2'b00, 3'b100,3'b011, 0,0));
    chk_ret("b_ret", 32'd6);

    op = IA;
    step("i_fetch", 1, f_r);
    step("i_dec", 0, dec(3'b001));
    step("i_exec", 0, v(0,0,0,0,0,0,0, 2'b00,2'b10,2'b01, 3'b001,3'b000, 0,0));
    step("i_wb", 0, wb(3'b001));
    op = LU;
    step("lui_fetch", 1, f_r);
    step("lui_dec", 0, dec(3'b010));
    step("lui_exec", 0, v(0,0,0,0,0,0,0, 2'b00,2'b00,2'b01, 3'b010,3'b101, 0,0));
    step("lui_wb", 0, wb(3'b010));
    op = AU;
    step("aui_fetch", 1, f_r);
    step("aui_dec", 0, dec(3'b010));
    step("aui_exec", 0, v(0,0,0,0,0,0,0, 2'b00,2'b01,2'b01, 3'b010,3'b100, 0,0));
    step("aui_wb", 0, wb(3'b010));
    chk_ret("u_ret", 32'd9);

    op = 7'b1111111;
    step("ill_fetch", 1, f_r);
    step("ill_dec", 1, dec(3'b000));
    for (int i = 0; i < 20; i++)
      step("ill_hold", logic'(i[0]), v(0,0,0,0,0,0,0, 2'b00,2'b00,2'b00, 3'b000,3'b000, 1,0));
    chk_ret("ill_ret", 32'd9);
    do_reset();
    step("ill_clr", 0, f_w);

    do_reset();
    for (int i = 0; i < 4; i++)
      step("to_wait", 0, f_w);
    for (int i = 0; i < 3; i++)
      step("to_buserr", 1, v(0,0,0,0,0,0,0, 2'b00,2'b00,2'b00, 3'b000,3'b000, 0,1));

    do_reset();
    op = R;
    for (int i = 0; i < 3; i++)
      step("lim_wait", 0, f_w);
    step("lim_ready", 1, f_r);
    step("lim_dec", 0, dec(3'b000));

    do_reset();
    op = ST;
    step("rs_fetch", 1, f_r);
    step("rs_dec", 0, dec(3'b011));
    step("rs_adr", 0, v(0,0,0,0,0,0,0, 2'b00,2'b10,2'b01, 3'b011,3'b010, 0,0));
    mem_ready = 1'b0;
    #1;
    chk("rs_wr", v(1,1,1,0,0,0,0, 2'b00,2'b00,2'b00, 3'b011,3'b000, 0,0));
    #2;
    rst_n = 1'b0;
    #1;
    chk("rs_async", z);
    chk_ret("rs_ret", 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    op = R;
    step("rs_fetch2", 1, f_r);
    step("rs_dec2", 0, dec(3'b000));
    step("rs_exec2", 0, v(0,0,0,0,0,0,0, 2'b00,2'b10,2'b00, 3'b000,3'b000, 0,0));
    step("rs_wb2", 0, wb(3'b000));
    chk_ret("rs_ret2", 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
